// File: rtl/mac_pkg.sv
// Shared FSM type and width-generic add/clamp helpers for MAC and adder-tree blocks.
// Helpers work in a MAX_W container; callers pass their real width and keep operands zero above it.
package mac_pkg;

  localparam int MAX_W = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } mac_state_t;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

  function automatic logic [MAX_W-1:0] acc_max(input int w, input bit sgn);
    return sgn ? (width_mask(w) >> 1) : width_mask(w);
  endfunction

  function automatic logic [MAX_W-1:0] acc_min(input int w, input bit sgn);
    return sgn ? (width_mask(w) ^ (width_mask(w) >> 1)) : '0;
  endfunction

  // Result is {sum, ovf}; sum is already clamped when sat is set.
  function automatic logic [MAX_W:0] sat_add(input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input int w, input bit sgn, input bit sat);
    logic [MAX_W:0]   full;
    logic [MAX_W-1:0] mask, msb, sum;
    logic             a_neg, b_neg, s_neg, ovf;
    mask  = width_mask(w);
    msb   = mask ^ (mask >> 1);
    full  = {1'b0, a & mask} + {1'b0, b & mask};
    sum   = full[MAX_W-1:0] & mask;
    a_neg = |(a & msb);
    b_neg = |(b & msb);
    s_neg = |(sum & msb);
    ovf   = sgn ? ((a_neg == b_neg) && (s_neg != a_neg)) : |(full & ~{1'b0, mask});
    if (ovf && sat) sum = (sgn && a_neg) ? acc_min(w, sgn) : acc_max(w, sgn);
    return {sum, ovf};
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational ACC_W-bit add with overflow flag and optional clamp to the representable range.
// Zero latency; purely combinational, no flow control.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int ACC_W    = 40,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [MAX_W-ACC_W-1:0] unused_hi;

  assign {unused_hi, sum, ovf} = sat_add(MAX_W'(a), MAX_W'(b), ACC_W, SIGNED != 0, SATURATE != 0);

endmodule

// File: rtl/mac_pe.sv
// Systolic MAC cell: forwards operands east/south, accumulates first/last-framed dot products.
// Forward latency 1 cycle, result 2 cycles after the last beat's sampling edge; no backpressure.
module mac_pe
  import mac_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 40,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              fwd_valid,
  output logic              fwd_first,
  output logic              fwd_last,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              acc_ovf,
  output logic              frame_err
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int EXT_W  = ACC_W - PROD_W;
  localparam bit SX     = (SIGNED != 0);

  logic [PROD_W-1:0] a_ext, b_ext, mul;
  logic [ACC_W-1:0]  prod_d, prod, acc, add_sum, acc_nxt;
  logic              p_vld, p_first, p_last;
  logic              add_ovf, ovf_sticky, ovf_nxt, restart;
  mac_state_t        state;

  // S1: operand/flag registers double as the east/south forwarding outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out     <= '0;
      b_out     <= '0;
      fwd_valid <= 1'b0;
      fwd_first <= 1'b0;
      fwd_last  <= 1'b0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      fwd_valid <= in_valid;
      fwd_first <= in_first;
      fwd_last  <= in_last;
    end
  end

  assign a_ext = {{DATA_W{SX & a_out[DATA_W-1]}}, a_out};
  assign b_ext = {{DATA_W{SX & b_out[DATA_W-1]}}, b_out};
  assign mul   = a_ext * b_ext;

  if (EXT_W > 0) begin : g_ext
    assign prod_d = {{EXT_W{SX & mul[PROD_W-1]}}, mul};
  end else begin : g_noext
    assign prod_d = mul;
  end

  // S2: product register only loads on valid beats to avoid needless toggling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld   <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      prod    <= '0;
    end else begin
      p_vld   <= fwd_valid;
      p_first <= fwd_first;
      p_last  <= fwd_last;
      if (fwd_valid) prod <= prod_d;
    end
  end

  mac_sat_add #(
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_add (
    .a  (acc),
    .b  (prod),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // A beat with no open frame starts one, whether or not it carries first
  always_comb begin
    restart = (state == IDLE) || p_first;
    acc_nxt = restart ? prod : add_sum;
    ovf_nxt = restart ? 1'b0 : (ovf_sticky | add_ovf);
  end

  // S3: accumulator, frame FSM and registered result outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      acc_out    <= '0;
      acc_ovf    <= 1'b0;
      acc_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      frame_err <= 1'b0;
      if (p_vld) begin
        acc        <= acc_nxt;
        ovf_sticky <= ovf_nxt;
        frame_err  <= (state == ACCUM) && p_first;
        if (p_last) begin
          acc_out   <= acc_nxt;
          acc_ovf   <= ovf_nxt;
          acc_valid <= 1'b1;
          state     <= IDLE;
        end else begin
          state     <= ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_pe.sv
// Scoreboard bench for mac_pe: five parameterisations share one stimulus bus, gated by sel.
// Expected sums come from an integer reference model and are matched to acc_valid pulses.
module tb_mac_pe;

  localparam int DW [5] = '{16, 8, 8, 8, 8};
  localparam int AW [5] = '{40, 40, 20, 20, 40};
  localparam int SG [5] = '{1, 1, 1, 1, 0};
  localparam int ST [5] = '{1, 1, 1, 0, 1};

  typedef struct {
    int     d;
    longint acc;
    bit     ovf;
    longint cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_first, in_last;
  logic [2:0]  sel;
  logic [15:0] a_in, b_in;
  logic [4:0]  vin, av, ao, fe;
  logic [15:0] a_out0, b_out0;
  logic        fv0, ff0, fl0;
  logic [7:0]  unused_a8 [1:4];
  logic [7:0]  unused_b8 [1:4];
  logic [4:1]  unused_fv, unused_ff, unused_fl;
  logic [39:0] acc0, acc1, acc4;
  logic [19:0] acc2, acc3;

  exp_t   sb[$];
  longint cyc = 0;
  longint macc [5];
  bit     movf [5];
  bit     open [5];
  int     exp_vld [5], vld_cnt [5], ferr_exp [5], ferr_cnt [5];
  int     checks = 0, failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar i = 0; i < 5; i++) begin : g_vin
    assign vin[i] = in_valid && (sel == 3'(i));
  end

  mac_pe #(.DATA_W(16), .ACC_W(40), .SIGNED(1), .SATURATE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(vin[0]), .in_first(in_first), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .a_out(a_out0), .b_out(b_out0),
    .fwd_valid(fv0), .fwd_first(ff0), .fwd_last(fl0),
    .acc_out(acc0), .acc_valid(av[0]), .acc_ovf(ao[0]), .frame_err(fe[0]));

  mac_pe #(.DATA_W(8), .ACC_W(40), .SIGNED(1), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(vin[1]), .in_first(in_first), .in_last(in_last),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .a_out(unused_a8[1]), .b_out(unused_b8[1]),
    .fwd_valid(unused_fv[1]), .fwd_first(unused_ff[1]), .fwd_last(unused_fl[1]),
    .acc_out(acc1), .acc_valid(av[1]), .acc_ovf(ao[1]), .frame_err(fe[1]));

  mac_pe #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SATURATE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(vin[2]), .in_first(in_first), .in_last(in_last),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .a_out(unused_a8[2]), .b_out(unused_b8[2]),
    .fwd_valid(unused_fv[2]), .fwd_first(unused_ff[2]), .fwd_last(unused_fl[2]),
    .acc_out(acc2), .acc_valid(av[2]), .acc_ovf(ao[2]), .frame_err(fe[2]));

  mac_pe #(.DATA_W(8), .ACC_W(20), .SIGNED(1), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst), .in_valid(vin[3]), .in_first(in_first), .in_last(in_last),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .a_out(unused_a8[3]), .b_out(unused_b8[3]),
    .fwd_valid(unused_fv[3]), .fwd_first(unused_ff[3]), .fwd_last(unused_fl[3]),
    .acc_out(acc3), .acc_valid(av[3]), .acc_ovf(ao[3]), .frame_err(fe[3]));

  mac_pe #(.DATA_W(8), .ACC_W(40), .SIGNED(0), .SATURATE(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(vin[4]), .in_first(in_first), .in_last(in_last),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .a_out(unused_a8[4]), .b_out(unused_b8[4]),
    .fwd_valid(unused_fv[4]), .fwd_first(unused_ff[4]), .fwd_last(unused_fl[4]),
    .acc_out(acc4), .acc_valid(av[4]), .acc_ovf(ao[4]), .frame_err(fe[4]));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint get_acc(input int d);
    case (d)
      0:       return longint'($signed(acc0));
      1:       return longint'($signed(acc1));
      2:       return longint'($signed(acc2));
      3:       return longint'($signed(acc3));
      default: return longint'(acc4);
    endcase
  endfunction

  function automatic longint pmod(input int d, input int a, input int b);
    longint span = longint'(1) << DW[d];
    longint x = longint'(a) & (span - 1);
    longint y = longint'(b) & (span - 1);
    if (SG[d] != 0) begin
      if (x >= span / 2) x -= span;
      if (y >= span / 2) y -= span;
    end
    return x * y;
  endfunction

  function automatic longint madd(input int d, input longint acc, input longint p, output bit o);
    longint span = longint'(1) << AW[d];
    longint lo = (SG[d] != 0) ? -(span / 2) : 0;
    longint hi = lo + span - 1;
    longint s = acc + p;
    o = (s > hi) || (s < lo);
    if (!o) return s;
    if (ST[d] != 0) return (s > hi) ? hi : lo;
    return (s > hi) ? s - span : s + span;
  endfunction

  task automatic beat(input int d, input int a, input int b, input bit f, input bit l);
    longint p, r;
    bit     o;
    p = pmod(d, a, b);
    if (!open[d] || f) begin
      if (open[d] && f) ferr_exp[d]++;
      macc[d] = p;
      movf[d] = 1'b0;
    end else begin
      r = madd(d, macc[d], p, o);
      macc[d] = r;
      movf[d] = movf[d] | o;
    end
    open[d] = !l;
    if (l) begin
      sb.push_back(exp_t'{d, macc[d], movf[d], cyc + 3});
      exp_vld[d]++;
    end
    sel = 3'(d); a_in = 16'(a); b_in = 16'(b);
    in_first = f; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      if (fe[i]) ferr_cnt[i]++;
      if (av[i]) begin
        vld_cnt[i]++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_dut", i, e.d);
          chk($sformatf("acc_out_u%0d", i), get_acc(i), e.acc);
          chk($sformatf("acc_ovf_u%0d", i), longint'(ao[i]), longint'(e.ovf));
          chk($sformatf("latency_u%0d", i), cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    sel = '0; a_in = '0; b_in = '0;
    #1 rst = 1'b0;
    idle(3);
    chk("rst_acc_out", get_acc(0), 0);
    chk("rst_acc_valid", longint'(av), 0);
    chk("rst_a_out", longint'(a_out0), 0);
    chk("rst_fwd_valid", longint'(fv0), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-beat frame and forwarding
    beat(0, 3, 4, 1'b1, 1'b1);
    chk("fwd_a_out", longint'(a_out0), 3);
    chk("fwd_b_out", longint'(b_out0), 4);
    chk("fwd_valid", longint'(fv0), 1);
    chk("fwd_first", longint'(ff0), 1);
    chk("fwd_last", longint'(fl0), 1);
    a_in = 16'd9; b_in = 16'd11;
    @(negedge clk);
    chk("fwd_a_bubble", longint'(a_out0), 9);
    chk("fwd_b_bubble", longint'(b_out0), 11);
    chk("fwd_valid_bubble", longint'(fv0), 0);
    idle(4);
    chk("acc_hold", get_acc(0), 12);
    chk("t1_vld_cnt", vld_cnt[0], exp_vld[0]);

    // Signed 8-bit frame with bubbles
    beat(1, 2, -3, 1'b1, 1'b0); idle(2);
    beat(1, 5, 5, 1'b0, 1'b0);  idle(1);
    beat(1, -4, -4, 1'b0, 1'b0); idle(3);
    beat(1, 7, 1, 1'b0, 1'b1);  idle(4);
    chk("t2_dot", get_acc(1), 42);
    chk("t2_vld_cnt", vld_cnt[1], 1);

    // Saturating and wrapping overflow, 20-bit accumulator
    for (int k = 0; k < 33; k++) beat(2, 127, 127, k == 0, k == 32);
    idle(4);
    chk("t3_sat", get_acc(2), 524287);
    chk("t3_sat_ovf", longint'(ao[2]), 1);
    for (int k = 0; k < 33; k++) beat(3, 127, 127, k == 0, k == 32);
    idle(4);
    chk("t3_wrap", get_acc(3), -516319);
    chk("t3_wrap_ovf", longint'(ao[3]), 1);

    // Unsigned, back-to-back frames; sticky flag must clear
    beat(4, 255, 255, 1'b1, 1'b0);
    beat(4, 255, 255, 1'b0, 1'b1);
    beat(4, 1, 1, 1'b1, 1'b1);
    idle(4);
    chk("t4_last", get_acc(4), 1);
    chk("t4_vld_cnt", vld_cnt[4], 2);

    // Abandoned frame, then implicit start without first
    beat(0, 2, 2, 1'b1, 1'b0);
    beat(0, 3, 3, 1'b0, 1'b0);
    beat(0, 1, 5, 1'b1, 1'b1);
    idle(4);
    chk("t5_ferr_cnt", ferr_cnt[0], 1);
    beat(0, 2, 3, 1'b0, 1'b1);
    idle(4);
    chk("t5_ferr_after_idle_start", ferr_cnt[0], ferr_exp[0]);
    chk("t5_acc", get_acc(0), 6);

    // Asynchronous reset in the middle of a frame
    beat(0, 4, 4, 1'b1, 1'b0);
    beat(0, 5, 5, 1'b0, 1'b0);
    #2 rst = 1'b0;
    for (int i = 0; i < 5; i++) open[i] = 1'b0;
    #2;
    chk("mid_rst_acc_out", get_acc(0), 0);
    chk("mid_rst_a_out", longint'(a_out0), 0);
    chk("mid_rst_fwd_valid", longint'(fv0), 0);
    chk("mid_rst_acc_valid", longint'(av), 0);
    chk("mid_rst_frame_err", longint'(fe), 0);
    @(negedge clk);
    idle(2);
    rst = 1'b1;
    idle(2);
    chk("t6_no_stale_vld", vld_cnt[0], exp_vld[0]);
    beat(0, 6, 7, 1'b1, 1'b1);
    idle(4);
    chk("t6_acc", get_acc(0), 42);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("vld_cnt_u%0d", i), vld_cnt[i], exp_vld[i]);
      chk($sformatf("ferr_cnt_u%0d", i), ferr_cnt[i], ferr_exp[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
